// File: rtl/athena_rom_pkg.sv
// Shared types and address-map tables for the Athena ROM loader.
package athena_rom_pkg;

  typedef enum logic [2:0] {
    RgMain, RgSub, RgAudio, RgSide, RgBack, RgSprite, RgYm, RgProm
  } region_e;

  localparam int unsigned NUM_REGIONS = 8;

  localparam logic [31:0] REGION_BASE [NUM_REGIONS] = '{
    32'h00000, 32'h10000, 32'h20000, 32'h30000,
    32'h38000, 32'h48000, 32'h68000, 32'h78000
  };

  localparam logic [31:0] REGION_LAST [NUM_REGIONS] = '{
    32'h0FFFF, 32'h1FFFF, 32'h2FFFF, 32'h37FFF,
    32'h47FFF, 32'h67FFF, 32'h77FFF, 32'h78BFF
  };

  localparam logic [31:0] MAP_END = 32'h78C00;

  localparam logic [7:0] IdxRom  = 8'd0;
  localparam logic [7:0] IdxGame = 8'd1;
  localparam logic [7:0] IdxDsw  = 8'd254;

  typedef enum logic [1:0] {StIdle, StActive, StWrite, StDone} loader_st_e;

endpackage

// File: rtl/athena_rom_loader_if.sv
// hps_io download stream plus the byte-write bus toward the ROM regions.
interface athena_rom_loader_if #(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned OFS_W  = 17
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic [2:0]        mem_sel;
  logic [OFS_W-1:0]  mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic              mem_ack;

  // Host side: hps_io stream source and memory acknowledger.
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    input  ioctl_wait, mem_sel, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    output ioctl_wait, mem_sel, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/athena_rom_decode.sv
// Combinational byte address -> {valid, region, offset-in-region} lookup.
module athena_rom_decode
  import athena_rom_pkg::*;
#(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned OFS_W  = 17
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              valid,
  output region_e           sel,
  output logic [OFS_W-1:0]  offset
);

  logic [31:0] addr_ext;
  logic [31:0] rel;

  assign addr_ext = 32'(addr);

  always_comb begin
    valid  = 1'b0;
    sel    = RgMain;
    offset = '0;
    rel    = '0;
    if (addr_ext < MAP_END) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        // Unsigned wrap makes addresses below the base fail the size test.
        rel = addr_ext - REGION_BASE[i];
        if (rel <= (REGION_LAST[i] - REGION_BASE[i])) begin
          valid  = 1'b1;
          sel    = region_e'(i[2:0]);
          offset = OFS_W'(rel);
        end
      end
    end
  end

endmodule

// File: rtl/athena_rom_loader.sv
// ROM download loader: routes hps_io index-0 bytes into region writes with a
// one-byte hold buffer. Define ATHENA_ROM_CHECKSUM_EN for the running byte sum.
module athena_rom_loader
  import athena_rom_pkg::*;
#(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned OFS_W  = 17
) (
  input  logic                i_clk,
  input  logic                RESETn,
  athena_rom_loader_if.slave  bus,
  output logic [7:0]          game,
  output logic [15:0]         dsw,
  output logic                load_done,
  output logic                load_err,
  output logic [15:0]         checksum
);

  loader_st_e       state_q;
  logic             dl_q;
  logic             mem_we_q;
  region_e          mem_sel_q;
  logic [OFS_W-1:0] mem_addr_q;
  logic [7:0]       mem_data_q;
  logic             hold_full_q;
  region_e          hold_sel_q;
  logic [OFS_W-1:0] hold_addr_q;
  logic [7:0]       hold_data_q;
  logic [7:0]       game_q;
  logic [15:0]      dsw_q;
  logic             load_done_q;
  logic             load_err_q;

  logic             dec_valid;
  region_e          dec_sel;
  logic [OFS_W-1:0] dec_offset;

  athena_rom_decode #(
    .ADDR_W (ADDR_W),
    .OFS_W  (OFS_W)
  ) u_decode (
    .addr   (bus.ioctl_addr),
    .valid  (dec_valid),
    .sel    (dec_sel),
    .offset (dec_offset)
  );

  logic rom_wr;
  logic new_ok;
  logic start_load;
  logic byte_acked;

  assign rom_wr     = bus.ioctl_wr && (bus.ioctl_index == IdxRom);
  assign new_ok     = rom_wr && dec_valid;
  assign start_load = ((state_q == StIdle) || (state_q == StDone)) &&
                      bus.ioctl_download && !dl_q && (bus.ioctl_index == IdxRom);
  assign byte_acked = (state_q == StWrite) && bus.mem_ack;

  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= StIdle;
      dl_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= RgMain;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      hold_full_q <= 1'b0;
      hold_sel_q  <= RgMain;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      game_q      <= '0;
      dsw_q       <= 16'hFFFF;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      dl_q <= bus.ioctl_download;

      if (bus.ioctl_wr && (bus.ioctl_index == IdxGame) && (bus.ioctl_addr == '0)) begin
        game_q <= bus.ioctl_dout;
      end
      if (bus.ioctl_wr && (bus.ioctl_index == IdxDsw)) begin
        if (bus.ioctl_addr == '0) begin
          dsw_q[7:0] <= bus.ioctl_dout;
        end else if (bus.ioctl_addr == ADDR_W'(1)) begin
          dsw_q[15:8] <= bus.ioctl_dout;
        end
      end

      unique case (state_q)
        StIdle, StDone: begin
          if (start_load) begin
            state_q     <= StActive;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
          end
        end
        StActive: begin
          if (new_ok) begin
            mem_sel_q  <= dec_sel;
            mem_addr_q <= dec_offset;
            mem_data_q <= bus.ioctl_dout;
            mem_we_q   <= 1'b1;
            state_q    <= StWrite;
          end else if (rom_wr) begin
            load_err_q <= 1'b1;
          end else if (!bus.ioctl_download) begin
            state_q     <= StDone;
            load_done_q <= 1'b1;
          end
        end
        StWrite: begin
          if (rom_wr && !dec_valid) begin
            load_err_q <= 1'b1;
          end
          if (byte_acked) begin
            // Keep mem_we high when another byte is ready so there is no gap.
            if (hold_full_q) begin
              mem_sel_q   <= hold_sel_q;
              mem_addr_q  <= hold_addr_q;
              mem_data_q  <= hold_data_q;
              hold_full_q <= new_ok;
              hold_sel_q  <= dec_sel;
              hold_addr_q <= dec_offset;
              hold_data_q <= bus.ioctl_dout;
            end else if (new_ok) begin
              mem_sel_q  <= dec_sel;
              mem_addr_q <= dec_offset;
              mem_data_q <= bus.ioctl_dout;
            end else begin
              mem_we_q <= 1'b0;
              if (bus.ioctl_download) begin
                state_q <= StActive;
              end else begin
                state_q     <= StDone;
                load_done_q <= 1'b1;
              end
            end
          end else if (new_ok) begin
            if (hold_full_q) begin
              load_err_q <= 1'b1;
            end else begin
              hold_full_q <= 1'b1;
              hold_sel_q  <= dec_sel;
              hold_addr_q <= dec_offset;
              hold_data_q <= bus.ioctl_dout;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ATHENA_ROM_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      checksum_q <= '0;
    end else if (start_load) begin
      checksum_q <= '0;
    end else if (byte_acked) begin
      checksum_q <= checksum_q + {8'h00, mem_data_q};
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign bus.ioctl_wait = (state_q == StWrite) || hold_full_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_sel    = mem_sel_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_data   = mem_data_q;
  assign game           = game_q;
  assign dsw            = dsw_q;
  assign load_done      = load_done_q;
  assign load_err       = load_err_q;

endmodule

// File: tb/tb_athena_rom_loader.sv
// Self-checking bench for athena_rom_loader: directed scenarios plus a random
// download, scored against a region-table model and an expected-write queue.
module tb_athena_rom_loader;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned OFS_W  = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  athena_rom_loader_if #(.ADDR_W(ADDR_W), .OFS_W(OFS_W)) bus ();

  logic [7:0]  game;
  logic [15:0] dsw;
  logic        load_done;
  logic        load_err;
  logic [15:0] checksum;

  athena_rom_loader #(
    .ADDR_W (ADDR_W),
    .OFS_W  (OFS_W)
  ) dut (
    .i_clk     (clk),
    .RESETn    (rst_n),
    .bus       (bus),
    .game      (game),
    .dsw       (dsw),
    .load_done (load_done),
    .load_err  (load_err),
    .checksum  (checksum)
  );

  typedef struct packed {
    logic [2:0]  sel;
    logic [16:0] ofs;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_acked = 0;
  int          we_cycles = 0;
  logic [15:0] model_sum = '0;
  bit          exp_err = 1'b0;
  bit          ack_en = 1'b1;
  int          ack_delay = 1;

  int unsigned base_tab [8] = '{'h00000, 'h10000, 'h20000, 'h30000,
                                'h38000, 'h48000, 'h68000, 'h78000};
  int unsigned size_tab [8] = '{'h10000, 'h10000, 'h10000, 'h08000,
                                'h10000, 'h20000, 'h10000, 'h00C00};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_map(input int unsigned a, output logic [2:0] sel,
                                   output logic [16:0] ofs);
    sel = '0;
    ofs = '0;
    for (int r = 0; r < 8; r++) begin
      if (a >= base_tab[r] && a < base_tab[r] + size_tab[r]) begin
        sel = 3'(r);
        ofs = 17'(a - base_tab[r]);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_csum();
`ifdef ATHENA_ROM_CHECKSUM_EN
    return 32'(model_sum);
`else
    return 32'h0;
`endif
  endfunction

  // Scoreboard: every accepted write must match the next expected byte.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n && bus.mem_we) we_cycles++;
    if (rst_n && bus.mem_we && bus.mem_ack) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_pending", 32'(exp_q.size()), 32'h1);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_sel", 32'(bus.mem_sel), 32'(e.sel));
        check_eq("wr_ofs", 32'(bus.mem_addr), 32'(e.ofs));
        check_eq("wr_data", 32'(bus.mem_data), 32'(e.data));
        model_sum = model_sum + 16'(e.data);
        n_acked++;
      end
    end
  end

  // Memory responder: pulse mem_ack ack_delay cycles into each request.
  initial begin : resp
    int wcnt;
    wcnt = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end else if (bus.mem_we && ack_en) begin
        if (wcnt >= ack_delay) bus.mem_ack = 1'b1;
        else wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [7:0] idx, input int unsigned a, input logic [7:0] d);
    tick();
    bus.ioctl_wr    = 1'b1;
    bus.ioctl_index = idx;
    bus.ioctl_addr  = ADDR_W'(a);
    bus.ioctl_dout  = d;
    tick();
    bus.ioctl_wr    = 1'b0;
  endtask

  task automatic push_exp(input int unsigned a, input logic [7:0] d);
    wr_t e;
    if (model_map(a, e.sel, e.ofs)) begin
      e.data = d;
      exp_q.push_back(e);
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.ioctl_wait && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) check_eq("wait_timeout", 32'(bus.ioctl_wait), 32'h0);
  endtask

  task automatic rom_byte(input int unsigned a, input logic [7:0] d);
    wait_ready();
    push_exp(a, d);
    host_wr(8'd0, a, d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bus.mem_we || bus.ioctl_wait) && n < 300) begin
      tick();
      n++;
    end
    check_eq("drain_we", 32'(bus.mem_we), 32'h0);
  endtask

  task automatic start_dl();
    tick();
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    model_sum = '0;
    exp_err = 1'b0;
    tick();
    check_eq("start_done_clr", 32'(load_done), 32'h0);
    check_eq("start_err_clr", 32'(load_err), 32'h0);
  endtask

  task automatic end_dl(input bit immediate);
    int n;
    tick();
    bus.ioctl_download = 1'b0;
    tick();
    n = 0;
    while (!immediate && !load_done && n < 300) begin
      tick();
      n++;
    end
    check_eq("load_done", 32'(load_done), 32'h1);
    check_eq("load_err", 32'(load_err), 32'(exp_err));
    check_eq("checksum", 32'(checksum), exp_csum());
    check_eq("sb_leftover", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin : main
    logic [7:0]  b1, b2, b3;
    int          snap, low_cnt, n;
    bit          got_first;
    int unsigned a;

    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) tick();
    check_eq("rst_we", 32'(bus.mem_we), 32'h0);
    check_eq("rst_wait", 32'(bus.ioctl_wait), 32'h0);
    check_eq("rst_dsw", 32'(dsw), 32'hFFFF);
    check_eq("rst_game", 32'(game), 32'h0);
    check_eq("rst_done", 32'(load_done), 32'h0);
    rst_n = 1'b1;
    tick();

    // Two bytes, ack one cycle after request, then an idle-bus download end.
    start_dl();
    ack_delay = 1;
    rom_byte('h00000, 8'hA5);
    rom_byte('h10005, 8'h3C);
    drain();
    end_dl(1'b1);

    // Slow ack with a second byte parked in the hold register.
    start_dl();
    ack_delay = 10;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    push_exp('h20000 + $urandom_range(0, 'hFFFF), b1);
    a = 'h48000 + $urandom_range(0, 'h1FFFF);
    push_exp(a, b2);
    host_wr(8'd0, exp_q[0].ofs + 'h20000, b1);
    host_wr(8'd0, a, b2);
    low_cnt = 0;
    got_first = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!bus.mem_we) break;
      if (!bus.ioctl_wait) low_cnt++;
      if (bus.mem_ack && !got_first) begin
        got_first = 1'b1;
        @(negedge clk);
        n++;
        check_eq("hold_next_we", 32'(bus.mem_we), 32'h1);
        check_eq("hold_next_data", 32'(bus.mem_data), 32'(b2));
        check_eq("hold_next_sel", 32'(bus.mem_sel), 32'h5);
        if (!bus.ioctl_wait) low_cnt++;
      end
    end
    check_eq("hold_first_ack", 32'(got_first), 32'h1);
    check_eq("wait_low_cycles", 32'(low_cnt), 32'h0);
    check_eq("hold_no_err", 32'(load_err), 32'h0);
    end_dl(1'b0);

    // Three writes while ack is withheld: third overruns.
    start_dl();
    ack_en = 1'b0;
    snap = n_acked;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    b3 = 8'($urandom);
    push_exp('h30000 + 1, b1);
    push_exp('h30000 + 2, b2);
    host_wr(8'd0, 'h30001, b1);
    host_wr(8'd0, 'h30002, b2);
    host_wr(8'd0, 'h30003, b3);
    check_eq("ovr_err", 32'(load_err), 32'h1);
    check_eq("ovr_wait", 32'(bus.ioctl_wait), 32'h1);
    exp_err = 1'b1;
    ack_delay = 1;
    ack_en = 1'b1;
    drain();
    check_eq("ovr_acked", 32'(n_acked - snap), 32'h2);
    end_dl(1'b0);

    // Map boundary: first address past the map, then the last mapped byte.
    start_dl();
    host_wr(8'd0, 'h78C00, 8'($urandom));
    check_eq("oom_err", 32'(load_err), 32'h1);
    check_eq("oom_no_we", 32'(bus.mem_we), 32'h0);
    exp_err = 1'b1;
    b1 = 8'($urandom);
    push_exp('h78BFF, b1);
    host_wr(8'd0, 'h78BFF, b1);
    drain();
    end_dl(1'b1);

    // Game/DIP side-channel writes never reach the memory bus.
    snap = we_cycles;
    host_wr(8'd1, 0, 8'h02);
    host_wr(8'd1, 1, 8'h55);
    host_wr(8'd254, 0, 8'h7F);
    host_wr(8'd254, 1, 8'hFE);
    host_wr(8'd254, 2, 8'h11);
    host_wr(8'd7, 0, 8'h99);
    tick();
    check_eq("game", 32'(game), 32'h02);
    check_eq("dsw", 32'(dsw), 32'hFE7F);
    check_eq("side_no_we", 32'(we_cycles - snap), 32'h0);

    // Random download with a host that honours ioctl_wait.
    start_dl();
    for (int i = 0; i < 40; i++) begin
      ack_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = 'h78C00 + $urandom_range(0, 'h3FF);
      else a = $urandom_range(0, 'h78BFF);
      rom_byte(a, 8'($urandom));
    end
    end_dl(1'b0);

    // Checksum wrap behaviour.
    start_dl();
    ack_delay = 1;
    rom_byte('h100, 8'hFF);
    rom_byte('h101, 8'hFF);
    rom_byte('h102, 8'h03);
    end_dl(1'b0);
`ifdef ATHENA_ROM_CHECKSUM_EN
    check_eq("csum_ff_ff_03", 32'(checksum), 32'h0000_0201);
`else
    check_eq("csum_tied_zero", 32'(checksum), 32'h0);
`endif

    // Reset pulse in the middle of a write.
    start_dl();
    ack_en = 1'b0;
    host_wr(8'd0, 'h30010, 8'h77);
    check_eq("pre_rst_we", 32'(bus.mem_we), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_we", 32'(bus.mem_we), 32'h0);
    check_eq("rst_wait2", 32'(bus.ioctl_wait), 32'h0);
    check_eq("rst_done2", 32'(load_done), 32'h0);
    check_eq("rst_err2", 32'(load_err), 32'h0);
    check_eq("rst_csum2", 32'(checksum), 32'h0);
    check_eq("rst_game2", 32'(game), 32'h0);
    check_eq("rst_dsw2", 32'(dsw), 32'hFFFF);
    check_eq("rst_sel2", 32'(bus.mem_sel), 32'h0);
    check_eq("rst_addr2", 32'(bus.mem_addr), 32'h0);
    check_eq("rst_data2", 32'(bus.mem_data), 32'h0);
    bus.ioctl_download = 1'b0;
    ack_en = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_we", 32'(bus.mem_we), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/athena_rom_loader.md
ATHENA_ROM_LOADER -- requirements
Module: athena_rom_loader

Interface
REQ-001 Parameter ADDR_W, default 25, width of ioctl_addr.
REQ-002 Parameter OFS_W, default 17, width of mem_addr (largest region offset).
REQ-003 i_clk  in  1  system clock (53.6 MHz); all logic on its rising edge.
REQ-004 RESETn  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download / ioctl_index / ioctl_wr  in  1/8/1  download stream control from hps_io.
REQ-006 ioctl_addr / ioctl_dout  in  ADDR_W/8  byte address and data.
REQ-007 ioctl_wait  out  1  back-pressure to hps_io.
REQ-008 mem_sel / mem_addr / mem_data  out  3/OFS_W/8  target region, offset in region, byte.
REQ-009 mem_we  out  1  write request, held until mem_ack; mem_ack  in  1  target accepted byte.
REQ-010 game / dsw  out  8/16  game select byte; DIP switches {sw1,sw0}.
REQ-011 load_done / load_err  out  1/1  ROM load complete; address-out-of-map or overrun seen.
REQ-012 checksum  out  16  running byte sum (see Configuration).

Function
REQ-013 Region map (base..last, byte): 0 main 0x00000-0x0FFFF; 1 sub 0x10000-0x1FFFF; 2 audio 0x20000-0x2FFFF; 3 side 0x30000-0x37FFF; 4 back 0x38000-0x47FFF; 5 sprite 0x48000-0x67FFF; 6 ym/adpcm 0x68000-0x77FFF; 7 colour PROM 0x78000-0x78BFF.
REQ-014 mem_sel = region of captured address; mem_addr = address minus region base, zero-extended.
REQ-015 FSM states IDLE, ACTIVE, WRITE, DONE; reset -> IDLE.
REQ-016 IDLE->ACTIVE on rising edge of ioctl_download with ioctl_index==0; clears load_done, load_err, checksum.
REQ-017 ACTIVE: ioctl_wr with in-map address captures byte; next cycle mem_we=1, ioctl_wait=1, state WRITE.
REQ-018 WRITE: mem_we, mem_sel, mem_addr, mem_data stable until cycle mem_ack=1; mem_we drops the cycle after.
REQ-019 One-byte hold register: ioctl_wr in WRITE stores byte; issued immediately after ack (no idle cycle); ioctl_wr with hold full -> byte dropped, load_err=1.
REQ-020 ioctl_wait = 1 whenever state is WRITE or hold register full; else 0.
REQ-021 Address >= 0x78C00: byte dropped, no mem_we, load_err=1, state unchanged.
REQ-022 Falling edge of ioctl_download: if no write pending -> DONE next cycle; else DONE one cycle after final ack.
REQ-023 DONE: load_done=1; new index-0 download -> ACTIVE per REQ-016.
REQ-024 ioctl_wr with ioctl_index==1, addr 0 -> game <= dout (any state); other addresses ignored.
REQ-025 ioctl_wr with ioctl_index==254, addr 0 -> dsw[7:0], addr 1 -> dsw[15:8]; addr >1 ignored.
REQ-026 ioctl_wr with other indices ignored; no mem_we.
REQ-027 mem_ack while not WRITE ignored.

Reset
REQ-028 RESETn low: state IDLE, mem_we=0, ioctl_wait=0, hold empty, load_done=0, load_err=0, checksum=0, mem_* =0, game=0, dsw=16'hFFFF.
REQ-029 Reset during WRITE abandons pending byte; mem_we drops asynchronously.

Configuration
REQ-030 Macro ATHENA_ROM_CHECKSUM_EN defined: checksum = 16-bit wrap-around sum of every byte acked into regions 0-7 since last REQ-016 clear.
REQ-031 Macro undefined: checksum tied to 0, no adder/register synthesised; all else identical.

Structure
REQ-032 Package athena_rom_pkg: region enum, REGION_BASE/REGION_LAST constant arrays, MAP_END=0x78C00, loader state enum.
REQ-033 Sub-module athena_rom_decode: combinational address -> {valid, sel, offset} from package tables.

Verification
REQ-034 Index-0 download, bytes 0x00000=0xA5, 0x10005=0x3C, mem_ack 1 cycle after mem_we -> mem_sel 0/ofs 0, then sel 1/ofs 5; load_done=1 after download falls.
REQ-035 mem_ack delayed 10 cycles, second ioctl_wr during WRITE -> ioctl_wait=1 throughout, held byte issued cycle after first ack, load_err=0.
REQ-036 Three ioctl_wr while ack withheld -> third dropped, load_err=1, only two mem_we.
REQ-037 Address 0x78C00 and 0x78BFF -> first dropped with load_err=1; second written sel 7 ofs 0xBFF.
REQ-038 Index 1 addr 0 = 0x02; index 254 addr 0 = 0x7F, addr 1 = 0xFE -> game=0x02, dsw=0xFE7F, no mem_we.
REQ-039 With ATHENA_ROM_CHECKSUM_EN, bytes 0xFF,0xFF,0x03 -> checksum=0x0201; RESETn pulse mid-WRITE -> all outputs at REQ-028 values.
